// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, memory freezes,
// branch flushes, saturating perf counters and a sticky memory-timeout flag.
module hazard_stall_unit #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TO_W    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             use_rs1_id,
    input  logic             use_rs2_id,
    input  logic [4:0]       rd_ex,
    input  logic             MemRead_ex,
    input  logic             RegWrite_ex,
    input  logic             branch_taken_ex,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             EXMEMWrite,
    output logic             MEMWBWrite,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

    localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic freeze;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;

    always_comb begin
        freeze   = dmem_req_mem & ~dmem_ready;
        rs1_hit  = use_rs1_id & (rs1_id == rd_ex);
        rs2_hit  = use_rs2_id & (rs2_id == rd_ex);
        load_use = MemRead_ex & RegWrite_ex & (rd_ex != 5'd0) & (rs1_hit | rs2_hit);
    end

    // Decode is purely combinational; reset forces the idle pattern without waiting for a clock.
    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEXWrite   = 1'b1;
        EXMEMWrite  = 1'b1;
        MEMWBWrite  = 1'b1;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        if (!reset) begin
            if (freeze) begin
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
                IDEXWrite  = 1'b0;
                EXMEMWrite = 1'b0;
                MEMWBWrite = 1'b0;
            end else if (branch_taken_ex) begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end else if (load_use) begin
                PCWrite     = 1'b0;
                IFIDWrite   = 1'b0;
                bubble_idex = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!PCWrite && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_ifid && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            RUN: begin
                if (freeze) begin
                    wait_cnt_d = TO_W'(1);
                    if (TIMEOUT <= 1) begin
                        state_d   = ERR;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!freeze) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_d >= TIMEOUT_C) begin
                        state_d   = ERR;
                        timeout_d = 1'b1;
                    end
                end
            end
            ERR:     timeout_d = 1'b1;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_timeout = timeout_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule
